imem_loader: RTL and testbench



---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_wr_port.sv | 33 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// FILL is only entered when IMEM_LOADER_ZFILL_EN is defined.
package imem_pkg;

  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_WORDS  = 512;

  // Word written into unused memory by the zero-fill pass
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    FILL = 2'd3
  } imem_state_e;

endpackage

// File: rtl/imem_wr_port.sv
// Registered write stage for instruction memory port A, shared by the
// stream-load and zero-fill paths.
module imem_wr_port
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina
);

  always_ff @(posedge clk) begin
    if (reset) begin
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      wea <= wr_en;
      if (wr_en) begin
        addra <= wr_addr;
        dina  <= wr_data;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory and holds the CPU until done.
// Optional zero-fill of the unused tail: define IMEM_LOADER_ZFILL_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W    = IMEM_DATA_W,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MEM_WORDS = IMEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_wea,
  output logic [ADDR_W-1:0] imem_addra,
  output logic [DATA_W-1:0] imem_dina,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(MEM_WORDS);

  imem_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic              xfer;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign xfer = in_valid && in_ready;

  always_comb begin
    in_ready = (state == LOAD);
    wr_en    = 1'b0;
    wr_addr  = ptr;
    wr_data  = in_data;
    if (state == LOAD && in_valid) begin
      wr_en = 1'b1;
    end
`ifdef IMEM_LOADER_ZFILL_EN
    else if (state == FILL) begin
      wr_en   = 1'b1;
      wr_data = DATA_W'(IMEM_NOP);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            ptr        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (word_count != FULL_COUNT) begin
              word_count <= word_count + (ADDR_W + 1)'(1);
            end
            // Last memory slot: finish here whether or not the stream ended
            if (ptr == LAST_ADDR) begin
              if (!in_last) begin
                overflow <= 1'b1;
              end
              state <= DONE;
            end else begin
              ptr <= ptr + ADDR_W'(1);
              if (in_last) begin
`ifdef IMEM_LOADER_ZFILL_EN
                state <= FILL;
`else
                state <= DONE;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_ZFILL_EN
        FILL: begin
          if (ptr == LAST_ADDR) begin
            state <= DONE;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
`endif
        DONE: begin
          // Release one edge after entry so the final write has landed
          if (start) begin
            state      <= LOAD;
            ptr        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
          end else begin
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  imem_wr_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_wr_port (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wea    (imem_wea),
    .addra  (imem_addra),
    .dina   (imem_dina)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed vector table, hand-written
// timing sequences and random streams checked against a memory-image model.
module tb_imem_loader;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NW = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          imem_wea;
  logic [AW-1:0] imem_addra;
  logic [DW-1:0] imem_dina;
  logic          cpu_hold;
  logic          done;
  logic [AW:0]   word_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int n;
    bit last;
    int gap_pct;
    int exp_count;
    bit exp_ovf;
  } vec_t;

  wr_t           wlog[$];
  logic [DW-1:0] mem_img [0:NW-1];
  logic [DW-1:0] prog [0:NW+15];
  int            hold_viol = 0;

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .imem_wea  (imem_wea),
    .imem_addra(imem_addra),
    .imem_dina (imem_dina),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .word_count(word_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Records every write the memory would perform on this edge
  always @(posedge clk) begin
    if (imem_wea === 1'b1) begin
      wlog.push_back('{a: imem_addra, d: imem_dina});
      mem_img[imem_addra] = imem_dina;
      if (cpu_hold !== 1'b1) hold_viol++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference: words accepted is the program length capped by memory depth
  function automatic int refCount(input int n, input bit last);
    if (last && n <= NW) return n;
    return NW;
  endfunction

  function automatic bit refOvf(input int n, input bit last);
    return !(last && n <= NW);
  endfunction

  task automatic waitDone(input string name);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 1100) begin
      tick();
      cyc++;
    end
    checkOutput(name, done, 1);
  endtask

  task automatic applyStimulus(input int n, input bit last, input int gap_pct,
                               input int exp_count, input bit exp_ovf);
    int  idx = 0;
    int  cyc = 0;
    int  bad = 0;
    bit  xf;
    wr_t expq[$];
    for (int i = 0; i < n; i++) prog[i] = $urandom;
    pulseStart();
    wlog.delete();
    hold_viol = 0;
    checkOutput("hold_after_start", cpu_hold, 1);
    while (idx < n && cyc < 1200) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = prog[idx];
      in_last  = last && (idx == n - 1);
      if (idx > 0 && !in_ready) break;
      xf = in_valid && in_ready;
      tick();
      if (xf) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("accepted", idx, exp_count);
    waitDone("done_rises");
    checkOutput("word_count", word_count, exp_count);
    checkOutput("overflow", overflow, exp_ovf);
    checkOutput("cpu_released", cpu_hold, 0);
    checkOutput("ready_low_done", in_ready, 0);
    for (int i = 0; i < exp_count; i++) expq.push_back('{a: AW'(i), d: prog[i]});
`ifdef IMEM_LOADER_ZFILL_EN
    if (!exp_ovf)
      for (int i = exp_count; i < NW; i++) expq.push_back('{a: AW'(i), d: '0});
`endif
    checkOutput("write_total", wlog.size(), expq.size());
    for (int i = 0; i < expq.size() && i < wlog.size(); i++)
      if (wlog[i] !== expq[i]) bad++;
    checkOutput("write_mismatches", bad, 0);
    checkOutput("hold_during_write", hold_viol, 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [DW-1:0] t1w[3];
    logic [DW-1:0] gw[5];
    int pat[5];
    int n;
    int gap;

    vecs[0] = '{n: 3,   last: 1'b1, gap_pct: 0,  exp_count: 3,   exp_ovf: 1'b0};
    vecs[1] = '{n: 20,  last: 1'b1, gap_pct: 40, exp_count: 20,  exp_ovf: 1'b0};
    vecs[2] = '{n: 1,   last: 1'b1, gap_pct: 0,  exp_count: 1,   exp_ovf: 1'b0};
    vecs[3] = '{n: 512, last: 1'b1, gap_pct: 10, exp_count: 512, exp_ovf: 1'b0};
    vecs[4] = '{n: 512, last: 1'b0, gap_pct: 0,  exp_count: 512, exp_ovf: 1'b1};
    vecs[5] = '{n: 513, last: 1'b0, gap_pct: 0,  exp_count: 512, exp_ovf: 1'b1};
    t1w = '{32'h04000001, 32'h08000002, 32'h0C000003};
    gw  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    pat = '{1, 0, 0, 1, 1};

    repeat (2) tick();
    checkOutput("rst_wea", imem_wea, 0);
    checkOutput("rst_addra", imem_addra, 0);
    checkOutput("rst_dina", imem_dina, 0);
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_hold", cpu_hold, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", word_count, 0);
    checkOutput("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();
    checkOutput("idle_ready", in_ready, 0);

    // Three back-to-back words: write one cycle after each transfer
    pulseStart();
    wlog.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = t1w[k];
      in_last  = (k == 2);
      checkOutput("t1_ready", in_ready, 1);
      tick();
      checkOutput("t1_wea", imem_wea, 1);
      checkOutput("t1_addr", imem_addra, k);
      checkOutput("t1_data", imem_dina, t1w[k]);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("t1_hold_still", cpu_hold, 1);
    checkOutput("t1_done_not_yet", done, 0);
    checkOutput("t1_ready_off", in_ready, 0);
    tick();
    checkOutput("t1_wea_off", imem_wea, 0);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_hold_off", cpu_hold, 0);
    checkOutput("t1_count", word_count, 3);
    checkOutput("t1_ovf", overflow, 0);

    // Valid gaps 1,0,0,1,1 with last on the final beat
    pulseStart();
    wlog.delete();
    for (int k = 0; k < 5; k++) begin
      in_valid = (pat[k] != 0);
      in_data  = gw[k];
      in_last  = (k == 4);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitDone("gap_done");
`ifndef IMEM_LOADER_ZFILL_EN
    checkOutput("gap_writes", wlog.size(), 3);
`endif
    checkOutput("gap_w0", wlog[0], {9'd0, gw[0]});
    checkOutput("gap_w1", wlog[1], {9'd1, gw[3]});
    checkOutput("gap_w2", wlog[2], {9'd2, gw[4]});
    checkOutput("gap_count", word_count, 3);

    // Valid outside LOAD must not write
    wlog.delete();
    in_valid = 1'b1;
    in_data  = 32'hBAD0BAD0;
    repeat (4) tick();
    in_valid = 1'b0;
    checkOutput("idle_valid_writes", wlog.size(), 0);

    for (int v = 0; v < 6; v++)
      applyStimulus(vecs[v].n, vecs[v].last, vecs[v].gap_pct, vecs[v].exp_count, vecs[v].exp_ovf);

    for (int r = 0; r < 6; r++) begin
      n   = $urandom_range(40, 1);
      gap = $urandom_range(60, 0);
      applyStimulus(n, 1'b1, gap, refCount(n, 1'b1), refOvf(n, 1'b1));
    end

    // Reload from DONE
    pulseStart();
    wlog.delete();
    checkOutput("reload_hold", cpu_hold, 1);
    checkOutput("reload_done_low", done, 0);
    checkOutput("reload_count_clr", word_count, 0);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitDone("reload_done");
    checkOutput("reload_mem0", mem_img[0], 32'hDEADBEEF);
    checkOutput("reload_count", word_count, 1);

    // Reset in the middle of a load
    pulseStart();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_wea", imem_wea, 0);
    checkOutput("mid_rst_hold", cpu_hold, 1);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_count", word_count, 0);
    checkOutput("mid_rst_ready", in_ready, 0);
    applyStimulus(2, 1'b1, 0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
